seq_nibble_adder: RTL and testbench
===================================

SEQ_NIBBLE_ADDER -- requirements
Module: seq_nibble_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op_sub, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-007 The block SHALL have port ready, output, 1 bit: high when start will be accepted.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port result, output, WIDTH bits: sum or difference.
REQ-010 The block SHALL have ports carry_out, overflow, zero and sign, output, 1 bit each: arithmetic flags.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 The block SHALL set ready=1 in IDLE and DONE, and ready=0 in RUN.
REQ-013 When start=1 and ready=1, the block SHALL capture a, b and op_sub, clear the nibble counter, and enter RUN.
REQ-014 The block SHALL store b as ~b and the initial carry as 1 when op_sub=1; otherwise it SHALL store b as-is with initial carry 0.
REQ-015 In RUN, the block SHALL process one 4-bit nibble per cycle, least-significant nibble first, using a 4-bit carry-lookahead slice.
REQ-016 The nibble carry-out SHALL be G | (P & carry_in), registered as the carry-in of the next nibble.
REQ-017 Each cycle in RUN, the captured operands SHALL shift right by 4, and the slice sum SHALL shift into the top of the result register.
REQ-018 The nibble counter SHALL be log2(WIDTH/4) bits wide, and RUN SHALL exit to DONE when the counter equals WIDTH/4-1.
REQ-019 done SHALL rise exactly WIDTH/4 cycles after the accepting edge (8 cycles for WIDTH=32), stay high for exactly one cycle in DONE, and then go low.
REQ-020 On the cycle done rises, the block SHALL update result and all flags together.
REQ-021 carry_out SHALL be the final nibble carry; for subtraction, 1 means no borrow.
REQ-022 overflow SHALL be set when a[MSB] equals the effective b[MSB] and result[MSB] differs from a[MSB].
REQ-023 zero SHALL equal (result == 0), and sign SHALL equal result[MSB].
REQ-024 result and flags SHALL hold their values until the next completed operation; they SHALL NOT change during RUN.
REQ-025 In DONE, start=1 SHALL be accepted, so back-to-back operations run with no idle cycle.
REQ-026 start=1 during RUN SHALL be ignored, and input changes during RUN SHALL have no effect.
REQ-027 If DONE sees start=0, the FSM SHALL return to IDLE.
REQ-028 The counter SHALL wrap to 0 on leaving RUN; no other wrap-around SHALL be reachable.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear to 0 the counter, the carry, the operand registers, result, done, carry_out, overflow, zero and sign.
REQ-030 While rst_n=0, ready SHALL be 1.
REQ-031 Reset asserted during RUN SHALL discard the partial result, and no done pulse SHALL follow.
REQ-032 start sampled on the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-033 The FSM state encodings and the constant NIBBLE=4 SHALL reside in the shared miniRISC package.
REQ-034 The datapath SHALL instantiate exactly one sub-module, cla_4_bit, as the nibble slice; its P/G outputs form the carry.
REQ-035 No WIDTH-wide adder SHALL be inferred.

Verification
REQ-036 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, carry_out=0, sign=1, zero=0; done exactly 8 cycles after start.
REQ-037 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out=1, zero=1, overflow=0.
REQ-038 sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry_out=0, sign=1.
REQ-039 sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow=1, carry_out=1.
REQ-040 start pulsed again at cycle 3 of RUN and a changed at cycle 4 -> the original result is unchanged, with a single done pulse at cycle 8.
REQ-041 rst_n=0 at cycle 4 of RUN, then a new add 2+3 -> no stale done pulse; result 0x00000005 after 8 cycles.

Source files
------------

// File: rtl/seq_nibble_adder_pkg.sv
// +----------------------------------------------------------------------+
// | seq_nibble_adder_pkg : shared miniRISC definitions (FSM encodings,   |
// |                        nibble size) for the sequential nibble adder  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_nibble_adder_pkg;

    localparam int NIBBLE = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage : seq_nibble_adder_pkg

`default_nettype wire

// File: rtl/seq_nibble_adder_cla.sv
// +----------------------------------------------------------------------+
// | cla_4_bit : 4-bit carry-lookahead slice with group propagate/generate|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cla_4_bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       p_o,
    output logic       g_o
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Internal carries are flattened lookahead terms, not a ripple chain.
    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);

    assign sum_o = p ^ c;
    assign p_o   = &p;
    assign g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla_4_bit

`default_nettype wire

// File: rtl/seq_nibble_adder.sv
// +----------------------------------------------------------------------+
// | seq_nibble_adder : multi-cycle add/sub, one nibble per clock, with   |
// |                    carry/overflow/zero/sign flags                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_nibble_adder
    import seq_nibble_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam int NIBBLES = WIDTH / NIBBLE;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    carry_q, carry_d;
    logic [WIDTH-1:0]        a_q, a_d;
    logic [WIDTH-1:0]        b_q, b_d;
    logic                    a_msb_q, a_msb_d;
    logic                    b_msb_q, b_msb_d;
    logic [WIDTH-NIBBLE-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    done_q, done_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;
    logic                    zero_q, zero_d;
    logic                    sign_q, sign_d;

    logic [NIBBLE-1:0]       nib_sum;
    logic                    nib_p;
    logic                    nib_g;
    logic                    nib_cout;
    logic [WIDTH-1:0]        shifted;

    cla_4_bit u_cla (
        .a_i   (a_q[NIBBLE-1:0]),
        .b_i   (b_q[NIBBLE-1:0]),
        .c_i   (carry_q),
        .sum_o (nib_sum),
        .p_o   (nib_p),
        .g_o   (nib_g)
    );

    assign nib_cout = nib_g | (nib_p & carry_q);
    // New nibble enters at the top; after the last nibble this is the full result.
    assign shifted  = {nib_sum, acc_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        sign_d   = sign_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> NIBBLE;
                b_d     = b_q >> NIBBLE;
                carry_d = nib_cout;
                acc_d   = shifted[WIDTH-1:NIBBLE];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = shifted;
                    cout_d   = nib_cout;
                    ovf_d    = (a_msb_q == b_msb_q) && (nib_sum[NIBBLE-1] != a_msb_q);
                    zero_d   = (shifted == '0);
                    sign_d   = nib_sum[NIBBLE-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
        end
    end

    assign ready     = !rst_n || (state_q != S_RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign sign      = sign_q;

endmodule : seq_nibble_adder

`default_nettype wire

// File: tb/tb_seq_nibble_adder.sv
// +----------------------------------------------------------------------+
// | tb_seq_nibble_adder : directed self-checking bench for the adder     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_nibble_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic        sign;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_res;

    seq_nibble_adder #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sub);
        start  = 1'b1;
        a      = av;
        b      = bv;
        op_sub = sub;
    endtask

    // Called #1 after an edge with start already raised; returns #1 after the done edge.
    task automatic wait_done(input string tag, input logic [31:0] er, input logic ec,
                             input logic eov, input logic ez, input logic es, input bit meddle);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check_val({tag, "_ready_run"}, ready, 0);
                check_val({tag, "_hold"}, result, last_res);
            end
            if (meddle && cyc == 3) start = 1'b1;
            if (meddle && cyc == 4) begin
                start  = 1'b0;
                a      = ~a;
                b      = ~b;
                op_sub = ~op_sub;
            end
            if (done) seen = 1'b1;
        end
        check_val({tag, "_latency"}, cyc, 8);
        check_val({tag, "_result"}, result, er);
        check_val({tag, "_flags"}, {carry_out, overflow, zero, sign}, {ec, eov, ez, es});
        check_val({tag, "_ready_done"}, ready, 1);
        last_res = er;
    endtask

    task automatic idle_step(input string tag);
        start = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_done_low"}, done, 0);
        check_val({tag, "_ready_idle"}, ready, 1);
        check_val({tag, "_result_kept"}, result, last_res);
    endtask

    initial begin
        int pulses;
        n_checks = 0;
        n_fail   = 0;
        last_res = '0;
        rst_n    = 1'b0;
        issue(32'h5, 32'h7, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", ready, 1);
        check_val("rst_state", {done, carry_out, overflow, zero, sign}, 5'b0);
        check_val("rst_result", result, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_ready", ready, 1);
        check_val("post_rst_done", done, 0);

        issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_step("add_ovf");

        issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_done("add_wrap", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_step("add_wrap");

        issue(32'h00000005, 32'h00000007, 1'b1);
        wait_done("sub_neg", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_step("sub_neg");

        issue(32'h80000000, 32'h00000001, 1'b1);
        wait_done("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step("sub_ovf");

        // Back-to-back: second op accepted in DONE.
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0);
        wait_done("add_mix", 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h00000010, 32'h00000010, 1'b1);
        wait_done("b2b_sub", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_step("b2b_sub");

        issue(32'h00000100, 32'h00000023, 1'b0);
        wait_done("meddle", 32'h00000123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_step("meddle");

        // Reset in the middle of RUN.
        issue(32'h11111111, 32'h22222222, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("midrst_done", done, 0);
        check_val("midrst_ready", ready, 1);
        check_val("midrst_result", result, 0);
        last_res = '0;
        rst_n    = 1'b1;
        pulses   = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("midrst_no_stale_done", pulses, 0);
        issue(32'h00000002, 32'h00000003, 1'b0);
        wait_done("after_rst", 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_step("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_nibble_adder

`default_nettype wire
